// File: rtl/tros_pkg.sv
// tros_pkg: shared definitions for the TROS measurement sequencer.
//   tros_state_e       - sequencer state encoding
//   CH_*               - oscillator channel codes presented on counter_select
//   DEFAULT_FRAME_BITS - serializer frame length (4-bit header + 20-bit count)
//   SYNC_DEPTH         - serializer synchroniser depth, added to every shift window
//   chan_code()        - maps a mask bit index to its channel code
package tros_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_LATCH,
    ST_SETTLE,
    ST_SELECT,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } tros_state_e;

  localparam logic [1:0] CH_NAND4     = 2'd0;
  localparam logic [1:0] CH_NAND4_CAP = 2'd1;
  localparam logic [1:0] CH_EINV_SUB  = 2'd2;

  localparam int unsigned DEFAULT_FRAME_BITS = 24;
  localparam int unsigned SYNC_DEPTH         = 3;

  // Mask bit index -> channel code; 2'b11 is never produced.
  function automatic logic [1:0] chan_code(input int unsigned idx);
    case (idx)
      0:       chan_code = CH_NAND4;
      1:       chan_code = CH_NAND4_CAP;
      default: chan_code = CH_EINV_SUB;
    endcase
  endfunction

endpackage

// File: rtl/tros_meas_sequencer.sv
// tros_meas_sequencer: sequences one measurement round of the TROS core:
// clear counters, open the gate, latch, settle, then serialise every enabled
// oscillator channel in ascending order, and pulse done.
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset
//   start               - begin a round (sampled in IDLE only)
//   continuous          - start the next round straight after DONE
//   abort               - cancel the round, back to IDLE, no done pulse
//   channel_mask[2:0]   - channels to read out (captured at round start)
//   gate_len            - gate time in clk cycles (captured; 0 behaves as 1)
//   ctr_reset, latch_counter, send_counter - measurement-core control pulses
//   counter_select[1:0] - channel presented to the serializer
//   busy                - high whenever not IDLE
//   done                - one-cycle end-of-round pulse
module tros_meas_sequencer
  import tros_pkg::*;
#(
  parameter int unsigned GATE_WIDTH  = 16,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FRAME_BITS  = DEFAULT_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic [2:0]            channel_mask,
  input  logic [GATE_WIDTH-1:0] gate_len,
  output logic                  ctr_reset,
  output logic                  latch_counter,
  output logic                  send_counter,
  output logic [1:0]            counter_select,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SHIFT_LEN = FRAME_BITS + SYNC_DEPTH;
  localparam int unsigned SHIFT_W   = $clog2(SHIFT_LEN + 1);
  localparam int unsigned TW_A      = (GATE_WIDTH > SHIFT_W) ? GATE_WIDTH : SHIFT_W;
  localparam int unsigned TW        = (TW_A > 4) ? TW_A : 4;

  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] SHIFT_LOAD = TW'(SHIFT_LEN - 1);

  tros_state_e           state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [GATE_WIDTH-1:0] gate_q, gate_d;
  logic [2:0]            mask_q, mask_d;
  logic [1:0]            sel_q, sel_d;
  logic                  ctr_reset_q, ctr_reset_d;
  logic                  latch_q, latch_d;
  logic                  send_q, send_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  lo_found, hi_found;
  logic [1:0]            lo_ch, hi_ch;

  // Lowest enabled channel, and lowest enabled channel above the current one.
  always_comb begin
    lo_found = 1'b0;
    lo_ch    = CH_NAND4;
    hi_found = 1'b0;
    hi_ch    = CH_NAND4;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!lo_found && mask_q[i]) begin
        lo_found = 1'b1;
        lo_ch    = chan_code(i);
      end
      if (!hi_found && mask_q[i] && (i > 32'(sel_q))) begin
        hi_found = 1'b1;
        hi_ch    = chan_code(i);
      end
    end
  end

  // Next state. The timer is loaded with (length-1) on state entry and the
  // state is left when it reaches zero, so one counter serves every phase.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
    gate_d  = gate_q;
    mask_d  = mask_q;
    sel_d   = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gate_d  = gate_len;
          mask_d  = channel_mask;
          state_d = ST_CLEAR;
          timer_d = HOLD_LOAD;
        end
      end
      ST_CLEAR: begin
        if (timer_q == '0) begin
          state_d = ST_GATE;
          timer_d = (gate_q == '0) ? '0 : TW'(gate_q) - TW'(1);
        end
      end
      ST_GATE: begin
        if (timer_q == '0) begin
          state_d = ST_LATCH;
          timer_d = HOLD_LOAD;
        end
      end
      ST_LATCH: begin
        if (timer_q == '0) begin
          state_d = ST_SETTLE;
          timer_d = HOLD_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          timer_d = '0;
          if (lo_found) begin
            state_d = ST_SELECT;
            sel_d   = lo_ch;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SELECT: begin
        state_d = ST_LOAD;
        timer_d = HOLD_LOAD;
      end
      ST_LOAD: begin
        if (timer_q == '0) begin
          state_d = ST_SHIFT;
          timer_d = SHIFT_LOAD;
        end
      end
      ST_SHIFT: begin
        if (timer_q == '0) begin
          timer_d = '0;
          if (hi_found) begin
            state_d = ST_SELECT;
            sel_d   = hi_ch;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (continuous) begin
          gate_d  = gate_len;
          mask_d  = channel_mask;
          state_d = ST_CLEAR;
          timer_d = HOLD_LOAD;
        end else begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end

    // Outputs are decoded from the next state so they are registered
    // alongside it and line up with the state they belong to.
    ctr_reset_d = (state_d == ST_CLEAR);
    latch_d     = (state_d == ST_LATCH);
    send_d      = (state_d == ST_LOAD);
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      gate_q      <= '0;
      mask_q      <= '0;
      sel_q       <= '0;
      ctr_reset_q <= 1'b0;
      latch_q     <= 1'b0;
      send_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_q      <= gate_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      ctr_reset_q <= ctr_reset_d;
      latch_q     <= latch_d;
      send_q      <= send_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign ctr_reset      = ctr_reset_q;
  assign latch_counter  = latch_q;
  assign send_counter   = send_q;
  assign counter_select = sel_q;
  assign done           = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_tros_meas_sequencer.sv
// Testbench for tros_meas_sequencer: builds the expected per-cycle output
// schedule of each round from the phase lengths and compares it cycle by cycle.
module tb_tros_meas_sequencer;
  import tros_pkg::*;

  localparam int unsigned GW    = 16;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned FB    = 24;
  localparam int unsigned SHIFT = FB + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    channel_mask = '0;
  logic [GW-1:0] gate_len = '0;
  logic          ctr_reset, latch_counter, send_counter, busy, done;
  logic [1:0]    counter_select;

  always #5 clk = ~clk;

  tros_meas_sequencer #(
    .GATE_WIDTH (GW),
    .HOLD_CYCLES(HOLD),
    .FRAME_BITS (FB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .channel_mask  (channel_mask),
    .gate_len      (gate_len),
    .ctr_reset     (ctr_reset),
    .latch_counter (latch_counter),
    .send_counter  (send_counter),
    .counter_select(counter_select),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic       ctr;
    logic       latch;
    logic       send;
    logic [1:0] sel;
    logic       done;
    logic       busy;
  } out_t;

  out_t       exp_q[$];
  out_t       act_q[$];
  logic [1:0] model_sel = 2'd0;
  int         checks = 0;
  int         errors = 0;

  function automatic out_t mk(input logic c, input logic l, input logic s,
                              input logic [1:0] sel, input logic d, input logic b);
    out_t o;
    o.ctr = c; o.latch = l; o.send = s; o.sel = sel; o.done = d; o.busy = b;
    return o;
  endfunction

  function automatic out_t obs();
    return mk(ctr_reset, latch_counter, send_counter, counter_select, done, busy);
  endfunction

  task automatic push_n(input int n, input logic c, input logic l, input logic s, input logic d);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(c, l, s, model_sel, d, 1'b1));
  endtask

  // One round: clear, gate, latch, settle, then per enabled channel
  // select(1) + load(HOLD) + shift(FRAME+sync), then the done cycle.
  task automatic model_round(input int gate, input logic [2:0] mask);
    push_n(HOLD, 1'b1, 1'b0, 1'b0, 1'b0);
    push_n((gate == 0) ? 1 : gate, 1'b0, 1'b0, 1'b0, 1'b0);
    push_n(HOLD, 1'b0, 1'b1, 1'b0, 1'b0);
    push_n(HOLD, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int ch = 0; ch < 3; ch++) begin
      if (mask[ch]) begin
        model_sel = 2'(ch);
        push_n(1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_n(HOLD, 1'b0, 1'b0, 1'b1, 1'b0);
        push_n(SHIFT, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    push_n(1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t o;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) step();
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, 2'd0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", o, mk(0, 0, 0, 2'd0, 0, 0));
    end
    start = 1'b0;
    rst_n = 1'b1;
    model_sel = 2'd0;
  endtask

  task automatic test_single_round();
    out_t o;
    exp_q.delete();
    act_q.delete();
    gate_len = 16'd10;
    channel_mask = 3'b001;
    start = 1'b1;
    step();
    start = 1'b0;
    model_round(10, 3'b001);
    foreach (exp_q[i]) begin
      o = obs();
      act_q.push_back(o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL single_round cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      step();
    end
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, model_sel, 0, 0)) begin
      errors++;
      $display("FAIL single_round_idle: got %b expected %b", o, mk(0, 0, 0, model_sel, 0, 0));
    end
    // Absolute timeline spot checks: act_q[k] is the value seen at edge N+1+k.
    checks++;
    if (act_q.size() != 55 || act_q[0].ctr !== 1'b1 || act_q[3].ctr !== 1'b1 || act_q[4].ctr !== 1'b0 ||
        act_q[14].latch !== 1'b1 || act_q[17].latch !== 1'b1 || act_q[18].latch !== 1'b0 ||
        act_q[22].sel !== 2'd0 || act_q[23].send !== 1'b1 || act_q[26].send !== 1'b1 ||
        act_q[27].send !== 1'b0 || act_q[54].done !== 1'b1 || act_q[53].done !== 1'b0) begin
      errors++;
      $display("FAIL single_round_timeline: got %0d cycles, required 55 with fixed pulse positions", act_q.size());
    end
  endtask

  task automatic test_random_rounds();
    out_t o;
    int   gate;
    logic [2:0] mask;
    for (int r = 0; r < 8; r++) begin
      exp_q.delete();
      gate = int'($urandom_range(0, 12));
      mask = 3'($urandom_range(0, 7));
      gate_len = GW'(gate);
      channel_mask = mask;
      start = 1'b1;
      step();
      model_round(gate, mask);
      foreach (exp_q[i]) begin
        o = obs();
        checks++;
        if (o !== exp_q[i]) begin
          errors++;
          $display("FAIL random_round %0d cycle %0d: got %b expected %b", r, i, o, exp_q[i]);
        end
        // Mid-round start pulses and input changes must not disturb the round.
        start = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        gate_len = GW'($urandom);
        channel_mask = 3'($urandom);
        step();
      end
      start = 1'b0;
      o = obs();
      checks++;
      if (o !== mk(0, 0, 0, model_sel, 0, 0)) begin
        errors++;
        $display("FAIL random_round_idle %0d: got %b expected %b", r, o, mk(0, 0, 0, model_sel, 0, 0));
      end
    end
  endtask

  task automatic test_zero_mask();
    out_t o;
    exp_q.delete();
    gate_len = '0;
    channel_mask = 3'b000;
    start = 1'b1;
    step();
    start = 1'b0;
    model_round(0, 3'b000);
    foreach (exp_q[i]) begin
      o = obs();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL zero_mask cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i == 13) begin
        checks++;
        if (o.done !== 1'b1) begin
          errors++;
          $display("FAIL zero_mask_done_at_14: got %b required 1", o.done);
        end
      end
      step();
    end
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, model_sel, 0, 0)) begin
      errors++;
      $display("FAIL zero_mask_idle: got %b expected %b", o, mk(0, 0, 0, model_sel, 0, 0));
    end
  endtask

  task automatic test_continuous();
    out_t o;
    int   len1;
    exp_q.delete();
    gate_len = 16'd6;
    channel_mask = 3'b010;
    continuous = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    model_round(6, 3'b010);
    len1 = exp_q.size();
    model_round(9, 3'b010);
    foreach (exp_q[i]) begin
      o = obs();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL continuous cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i == 0) gate_len = 16'd9;
      if (i == len1 + HOLD + 2) continuous = 1'b0;
      step();
    end
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, model_sel, 0, 0)) begin
      errors++;
      $display("FAIL continuous_idle: got %b expected %b", o, mk(0, 0, 0, model_sel, 0, 0));
    end
  endtask

  task automatic test_abort();
    out_t o;
    int   bad;
    exp_q.delete();
    gate_len = 16'd3;
    channel_mask = 3'b001;
    start = 1'b1;
    step();
    start = 1'b0;
    model_round(3, 3'b001);
    for (int i = 0; i <= 17; i++) begin
      o = obs();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_prefix cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      if (i == 17) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, 2'd0, 0, 0)) begin
      errors++;
      $display("FAIL abort_in_load: got %b expected %b", o, mk(0, 0, 0, 2'd0, 0, 0));
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || send_counter !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles after abort, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    out_t o;
    exp_q.delete();
    gate_len = 16'd20;
    channel_mask = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    model_round(20, 3'b111);
    for (int i = 0; i <= 6; i++) begin
      o = obs();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_prefix cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, 2'd0, 0, 0)) begin
      errors++;
      $display("FAIL reset_in_gate: got %b expected %b", o, mk(0, 0, 0, 2'd0, 0, 0));
    end
    model_sel = 2'd0;
    rst_n = 1'b1;
    exp_q.delete();
    gate_len = 16'd2;
    channel_mask = 3'b100;
    start = 1'b1;
    step();
    start = 1'b0;
    model_round(2, 3'b100);
    foreach (exp_q[i]) begin
      o = obs();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL after_reset_round cycle %0d: got %b expected %b", i, o, exp_q[i]);
      end
      step();
    end
    o = obs();
    checks++;
    if (o !== mk(0, 0, 0, model_sel, 0, 0)) begin
      errors++;
      $display("FAIL after_reset_idle: got %b expected %b", o, mk(0, 0, 0, model_sel, 0, 0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_round();
    test_random_rounds();
    test_zero_mask();
    test_continuous();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tros_meas_sequencer.md
TROS_MEAS_SEQUENCER -- requirements
Module: tros_meas_sequencer

Interface
REQ-001 SHALL have parameter GATE_WIDTH, default 16, width of the gate-length input.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, duration of every control pulse into slower or synchronised domains; legal range 1..15.
REQ-003 SHALL have parameter FRAME_BITS, default 24, serializer frame length (4-bit header plus 20-bit count).
REQ-004 SHALL have ports: clk  in  1  system clock; all logic on the rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: start  in  1  begin one measurement round, sampled when IDLE.
REQ-007 SHALL have ports: continuous  in  1  restart a new round automatically after DONE.
REQ-008 SHALL have ports: abort  in  1  cancel the round.
REQ-009 SHALL have ports: channel_mask  in  3  enables readout of oscillator channels 0 (nand4), 1 (nand4_cap) and 2 (einv_sub).
REQ-010 SHALL have ports: gate_len  in  GATE_WIDTH  gate time in clk cycles.
REQ-011 SHALL have ports: ctr_reset, latch_counter, send_counter  out  1 each  measurement-core controls.
REQ-012 SHALL have ports: counter_select  out  2  channel presented to the serializer.
REQ-013 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-014 SHALL have ports: done  out  1  one-cycle end-of-round pulse.

Function
REQ-015 States SHALL be IDLE, CLEAR, GATE, LATCH, SETTLE, SELECT, LOAD, SHIFT and DONE, with a single shared down-counter timer.
REQ-016 IDLE: when start=1, SHALL go to CLEAR; gate_len and channel_mask are captured into internal registers at this point.
REQ-017 CLEAR: ctr_reset=1 for exactly HOLD_CYCLES cycles, then GATE.
REQ-018 GATE: all controls are low for max(gate_len,1) cycles, then LATCH; gate_len=0 is treated as 1.
REQ-019 LATCH: latch_counter=1 for HOLD_CYCLES cycles, then SETTLE.
REQ-020 SETTLE: all controls are low for HOLD_CYCLES cycles, then SELECT for the lowest enabled channel, or DONE if the captured mask=0.
REQ-021 SELECT: counter_select=channel for 1 cycle, then LOAD.
REQ-022 LOAD: send_counter=1 for HOLD_CYCLES cycles, then SHIFT.
REQ-023 SHIFT: send_counter=0 for FRAME_BITS+3 cycles (3 = serializer synchroniser depth), then SELECT for the next higher enabled channel, or DONE.
REQ-024 counter_select SHALL hold its value from SELECT through the end of SHIFT, and SHALL otherwise hold its last value (reset value 0).
REQ-025 Channel encoding 2'b11 SHALL never be driven.
REQ-026 DONE: done=1 for 1 cycle; the next state SHALL be CLEAR if continuous=1 (recapturing gate_len and mask), otherwise IDLE.
REQ-027 abort=1 in any non-IDLE state SHALL move the block to IDLE on the next edge, with all pulse outputs low and no done pulse; abort SHALL take priority over every other transition.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 Changes to gate_len or channel_mask mid-round SHALL have no effect until the next capture.
REQ-030 continuous dropping mid-round SHALL let the current round finish, then go to IDLE.
REQ-031 Outputs SHALL be registered, with at most one of ctr_reset, latch_counter and send_counter high in any cycle.

Reset
REQ-032 On a clock edge with rst_n=0, the block SHALL go to IDLE, with ctr_reset, latch_counter, send_counter, done and busy = 0, counter_select=0, and the timer, captured gate and mask cleared.
REQ-033 Reset mid-round SHALL behave as abort, with no done pulse.
REQ-034 The first start SHALL be accepted on the first edge after rst_n returns high.

Structure
REQ-035 Shared package tros_pkg SHALL hold the state encoding, the channel codes (CH_NAND4=0, CH_NAND4_CAP=1, CH_EINV_SUB=2), the default FRAME_BITS=24 and the SYNC_DEPTH=3 constant; the top level and this block SHALL both use it.
REQ-036 There SHALL be no sub-module; the single timer and the next-channel priority search SHALL be inline.

Verification
REQ-037 Default parameters, mask=001, gate_len=10, start pulsed at edge N -> ctr_reset high N+1..N+4; latch_counter high N+15..N+18; counter_select=0 from N+23; send_counter high N+24..N+27; done at N+55; busy low at N+56.
REQ-038 mask=101, gate_len=5 -> two frames, channel 0 then channel 2, each SELECT->SHIFT block lasting 32 cycles; channel 1 never selected; one done pulse.
REQ-039 mask=000, gate_len=0 -> ctr_reset for 4 cycles; gate of 1 cycle; latch; settle; done 14 cycles after start; send_counter never high.
REQ-040 continuous=1, mask=010 -> after done, ctr_reset rises the next cycle; deasserting continuous during the second GATE -> that round completes, then IDLE.
REQ-041 abort in LOAD -> next cycle IDLE, send_counter=0, no done; rst_n=0 during GATE -> all outputs 0; start during busy is ignored (round timing unchanged).
